sram_bank_sdp: RTL

Parametrised simple-dual-port SRAM bank: one write port and one read port usable in the same cycle. It replaces the single-port bank in the GEMM buffer hierarchy (weight, activation and output buffers). It adds byte-enable writes and a configurable read pipeline depth. It adds a selectable read-during-write policy and a hardware clear engine, so memory contents never need a reset loop, which keeps the array synthesisable as RAM.

---
 rtl/sram_bank_sdp.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/sram_bank_sdp.sv
// sram_bank_sdp: simple-dual-port SRAM bank with byte-enable writes,
// pipelined reads, read-during-write policy and a zero-fill engine.
module sram_bank_sdp #(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 2**ADDR_WIDTH,
  parameter int RD_LATENCY = 1,
  parameter int RDW_MODE   = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_clr_start,
  output logic                             o_clr_busy,
  input  logic                             i_wr_en,
  input  logic [ADDR_WIDTH-1:0]            i_wr_addr,
  input  logic [DATA_WIDTH-1:0]            i_wr_data,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] i_wr_be,
  input  logic                             i_rd_en,
  input  logic [ADDR_WIDTH-1:0]            i_rd_addr,
  output logic [DATA_WIDTH-1:0]            o_rd_data,
  output logic                             o_rd_valid
);

  localparam int NB = DATA_WIDTH / BYTE_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_W =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (i_clr_start) state_d = CLEAR;
      end
      CLEAR: begin
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic idle;
  logic wr_in;
  logic rd_in;
  logic rd_acc;

  assign idle   = (state_q == IDLE);
  assign wr_in  = ({1'b0, i_wr_addr} < DEPTH_W);
  assign rd_in  = ({1'b0, i_rd_addr} < DEPTH_W);
  assign rd_acc = idle & i_rd_en;

  assign o_clr_busy = ~idle;

  // The clear engine owns the write port while it runs.
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_wa;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic [NB-1:0]         mem_be;

  always_comb begin
    mem_we = 1'b0;
    mem_wa = i_wr_addr;
    mem_wd = i_wr_data;
    mem_be = i_wr_be;
    if (!idle) begin
      mem_we = 1'b1;
      mem_wa = cnt_q;
      mem_wd = '0;
      mem_be = '1;
    end else begin
      mem_we = i_wr_en & wr_in;
    end
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < NB; k++) begin
        if (mem_be[k]) begin
          mem[mem_wa][k*BYTE_WIDTH +: BYTE_WIDTH] <=
            mem_wd[k*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  logic [DATA_WIDTH-1:0] rd_word;

  always_comb begin
    rd_word = '0;
    if (rd_in) begin
      rd_word = mem[i_rd_addr];
      if (RDW_MODE == 1 && i_wr_en && i_wr_addr == i_rd_addr) begin
        for (int k = 0; k < NB; k++) begin
          if (i_wr_be[k]) begin
            rd_word[k*BYTE_WIDTH +: BYTE_WIDTH] =
              i_wr_data[k*BYTE_WIDTH +: BYTE_WIDTH];
          end
        end
      end
    end
  end

  // Data stages only load on valid so the output holds between results.
  logic [DATA_WIDTH-1:0] pd_q [RD_LATENCY];
  logic [RD_LATENCY-1:0] pv_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pv_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) begin
        pd_q[i] <= '0;
      end
    end else begin
      pv_q[0] <= rd_acc;
      if (rd_acc) pd_q[0] <= rd_word;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pv_q[i] <= pv_q[i-1];
        if (pv_q[i-1]) pd_q[i] <= pd_q[i-1];
      end
    end
  end

  assign o_rd_valid = pv_q[RD_LATENCY-1];
  assign o_rd_data  = pd_q[RD_LATENCY-1];

endmodule
